// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: shared state type and constants for the sequential divider.
// Build option SIGNED_DIV_EN adds the FIX state used for signed results.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN
`ifdef SIGNED_DIV_EN
        ,
        FIX
`endif
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if: start/operand/result bundle of the sequential divider.
// Build option SIGNED_DIV_EN adds the signed_op request bit.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef SIGNED_DIV_EN
    logic             signed_op;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

`ifdef SIGNED_DIV_EN
    modport master (
        output start, dividend, divisor, signed_op,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor, signed_op,
        output busy, done, quotient, remainder, div_by_zero
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
`endif

endinterface

// File: rtl/seq_divider_step.sv
// seq_divider_step: one restoring-division iteration (shift, complement-add,
// select). Pure combinational; no build options.
module seq_divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           no_borrow;

    // Shifted remainder is below 2*D, so a negative trial shows up in bit WIDTH.
    always_comb begin
        shifted   = {r, q[WIDTH-1]};
        trial     = shifted + {1'b1, ~d} + (WIDTH+1)'(1);
        no_borrow = ~trial[WIDTH];
        r_next    = no_borrow ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        q_next    = {q[WIDTH-2:0], no_borrow};
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// Build option SIGNED_DIV_EN adds signed operands and a sign-fix cycle.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input logic          clk,
    input logic          rst_n,
    seq_divider_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] d_reg;
    logic [WIDTH-1:0] r_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] step_r;
    logic [WIDTH-1:0] step_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic             zero_flag;
    logic             done_pulse;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             accept;
    logic             zero_div;
    logic             last;
`ifdef SIGNED_DIV_EN
    logic             a_neg;
    logic             b_neg;
    logic             neg_q;
    logic             neg_r;
`endif

    assign accept   = (state == IDLE) && bus.start;
    assign zero_div = (bus.divisor == '0);
    assign last     = (cnt == CNT_W'(WIDTH - 1));

    assign bus.busy        = (state != IDLE);
    assign bus.done        = done_pulse;
    assign bus.quotient    = res_q;
    assign bus.remainder   = res_r;
    assign bus.div_by_zero = zero_flag;

    // Operand magnitudes fed into the iteration registers on accept.
    always_comb begin
`ifdef SIGNED_DIV_EN
        a_neg = bus.signed_op && bus.dividend[WIDTH-1];
        b_neg = bus.signed_op && bus.divisor[WIDTH-1];
        a_mag = a_neg ? ~bus.dividend + WIDTH'(1) : bus.dividend;
        b_mag = b_neg ? ~bus.divisor + WIDTH'(1) : bus.divisor;
`else
        a_mag = bus.dividend;
        b_mag = bus.divisor;
`endif
    end

    seq_divider_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r      (r_reg),
        .q      (q_reg),
        .d      (d_reg),
        .r_next (step_r),
        .q_next (step_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: a zero divisor is answered straight from IDLE.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.start && !zero_div) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
`ifdef SIGNED_DIV_EN
                    state_next = FIX;
`else
                    state_next = IDLE;
`endif
                end
            end
`ifdef SIGNED_DIV_EN
            FIX: begin
                state_next = IDLE;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture, iteration, counter and held results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            d_reg      <= '0;
            r_reg      <= '0;
            q_reg      <= '0;
            res_q      <= '0;
            res_r      <= '0;
            zero_flag  <= 1'b0;
            done_pulse <= 1'b0;
`ifdef SIGNED_DIV_EN
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
`endif
        end else begin
            done_pulse <= 1'b0;
            if (accept) begin
                if (zero_div) begin
                    res_q      <= '1;
                    res_r      <= bus.dividend;
                    zero_flag  <= 1'b1;
                    done_pulse <= 1'b1;
                end else begin
                    zero_flag <= 1'b0;
                    d_reg     <= b_mag;
                    q_reg     <= a_mag;
                    r_reg     <= '0;
                    cnt       <= '0;
`ifdef SIGNED_DIV_EN
                    neg_q     <= a_neg ^ b_neg;
                    neg_r     <= a_neg;
`endif
                end
            end else if (state == RUN) begin
                r_reg <= step_r;
                q_reg <= step_q;
                cnt   <= cnt + CNT_W'(1);
`ifndef SIGNED_DIV_EN
                if (last) begin
                    res_q      <= step_q;
                    res_r      <= step_r;
                    done_pulse <= 1'b1;
                end
`endif
            end
`ifdef SIGNED_DIV_EN
            else if (state == FIX) begin
                res_q      <= neg_q ? ~q_reg + WIDTH'(1) : q_reg;
                res_r      <= neg_r ? ~r_reg + WIDTH'(1) : r_reg;
                done_pulse <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: vector table plus hand-written corner sequences for
// seq_divider; results go through an expected-value queue. SIGNED_DIV_EN aware.
module tb_seq_divider;

    localparam int W = 32;
`ifdef SIGNED_DIV_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sop;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } vec_t;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t vecs[$];
    exp_t mon_e;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(
        .WIDTH (W),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected done=0");
            end else begin
                mon_e = sb.pop_front();
                check("quotient", bus.quotient, mon_e.q);
                check("remainder", bus.remainder, mon_e.r);
                check("div_by_zero", W'(bus.div_by_zero), W'(mon_e.dz));
            end
        end
    end

    task automatic add(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic sop, input logic [W-1:0] q,
                       input logic [W-1:0] r, input logic dz);
        vec_t v;
        v.a = a; v.b = b; v.sop = sop; v.q = q; v.r = r; v.dz = dz;
        vecs.push_back(v);
    endtask

    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic sop, input logic [W-1:0] q,
                            input logic [W-1:0] r, input logic dz);
        exp_t e;
        e.q = q; e.r = r; e.dz = dz;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef SIGNED_DIV_EN
        bus.signed_op = sop;
`else
        if (sop) $display("note: signed_op ignored in unsigned build");
`endif
        bus.start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // polls: negedges counted from just after the accept edge until done.
    task automatic wait_done(input string name, input int polls);
        int n = 0;
        while (n < polls + 8) begin
            @(negedge clk);
            n++;
            if (bus.done) break;
        end
        checks++;
        if (!bus.done || n != polls) begin
            errors++;
            $display("FAIL %s_latency: got %0d polls expected %0d",
                     name, n, polls);
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef SIGNED_DIV_EN
        bus.signed_op = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_busy", W'(bus.busy), '0);
        check("reset_done", W'(bus.done), '0);
        check("reset_quotient", bus.quotient, '0);
        check("reset_remainder", bus.remainder, '0);
        check("reset_dz", W'(bus.div_by_zero), '0);
        rst_n = 1'b1;
        @(negedge clk);

        add(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        add(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0);
        add(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
        add(32'd1234, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd1234, 1'b1);
        add(32'd8, 32'd2, 1'b0, 32'd4, 32'd0, 1'b0);
        add(32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0);
        add(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'd1, 32'd0, 1'b0);
        add(32'h80000000, 32'd3, 1'b0, 32'h2AAAAAAA, 32'd2, 1'b0);
        add(32'd0, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b1);
        add(32'd7, 32'd7, 1'b0, 32'd1, 32'd0, 1'b0);
`ifdef SIGNED_DIV_EN
        add(32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        add(32'd100, 32'hFFFFFFF9, 1'b1, 32'hFFFFFFF2, 32'd2, 1'b0);
        add(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
        add(32'hFFFFFFF9, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b1);
        add(32'hFFFFFF9C, 32'd7, 1'b0, 32'd613566742, 32'd2, 1'b0);
`endif

        // Back-to-back: each op starts in the done cycle of the previous one.
        for (int i = 0; i < vecs.size(); i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].sop,
                     vecs[i].q, vecs[i].r, vecs[i].dz);
            wait_done($sformatf("vec%0d", i), (vecs[i].b == '0) ? 1 : LAT + 1);
        end

        // Restart while busy is ignored; restart in done cycle is taken.
        start_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        repeat (9) @(negedge clk);
        check("busy_mid_run", W'(bus.busy), W'(1));
        bus.dividend = 32'd9;
        bus.divisor  = 32'd3;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_done("ignored_restart", LAT - 8);
        start_op(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);
        wait_done("done_cycle_start", LAT + 1);
        @(negedge clk);
        check("done_one_cycle", W'(bus.done), '0);
        check("idle_after_done", W'(bus.busy), '0);

        // Reset mid-run aborts without a done pulse.
        start_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("abort_busy", W'(bus.busy), '0);
        check("abort_done", W'(bus.done), '0);
        check("abort_quotient", bus.quotient, '0);
        check("abort_remainder", bus.remainder, '0);
        check("abort_dz", W'(bus.div_by_zero), '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (LAT + 3) @(negedge clk);
        check("post_abort_busy", W'(bus.busy), '0);
        start_op(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);
        wait_done("after_reset", LAT + 1);
        repeat (3) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_results: got %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
